// File: rtl/demux1to16_capture.sv
// Serial-to-parallel capture: steers one accepted bit per beat into channel sel,
// then presents the reassembled word with a one-cycle strobe. Optional parity beat via DEMUX_PARITY_EN.
module demux1to16_capture #(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  dout,
  output logic             dout_valid,
  output logic             busy
`ifdef DEMUX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              beat;
`ifdef DEMUX_PARITY_EN
  logic              par_phase_q, par_phase_d;
  logic              par_bit_q, par_bit_d;
  logic              parity_err_q, parity_err_d;
`endif

  assign beat = in_valid && (state_q == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par_phase_q  <= 1'b0;
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef DEMUX_PARITY_EN
      par_phase_q  <= par_phase_d;
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_phase_d  = par_phase_q;
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          sel_d    = '0;
          shadow_d = '0;
`ifdef DEMUX_PARITY_EN
          par_phase_d = 1'b0;
`endif
        end
      end
      CAPTURE: begin
        // abort outranks a beat landing in the same cycle
        if (abort) begin
          state_d  = IDLE;
          sel_d    = '0;
          shadow_d = '0;
`ifdef DEMUX_PARITY_EN
          par_phase_d = 1'b0;
`endif
        end else if (beat) begin
`ifdef DEMUX_PARITY_EN
          if (par_phase_q) begin
            par_bit_d   = in_bit;
            par_phase_d = 1'b0;
            sel_d       = '0;
            state_d     = DONE;
          end else begin
            shadow_d[sel_q] = in_bit;
            // sel parks on the last channel while the parity beat is taken
            if (sel_q == LAST_SEL) par_phase_d = 1'b1;
            else                   sel_d       = sel_q + 1'b1;
          end
`else
          shadow_d[sel_q] = in_bit;
          sel_d           = sel_q + 1'b1;
          if (sel_q == LAST_SEL) state_d = DONE;
`endif
        end
      end
      DONE: begin
        dout_d       = shadow_q;
        dout_valid_d = 1'b1;
`ifdef DEMUX_PARITY_EN
        parity_err_d = (^shadow_q) ^ par_bit_q;
`endif
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == CAPTURE);
  assign busy       = (state_q == CAPTURE);
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`ifdef DEMUX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_demux1to16_capture.sv
// Randomized self-checking bench for demux1to16_capture; a frame-level model
// tracks the last completed word and the strobe count.
module tb_demux1to16_capture;

`ifdef DEMUX_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_ready;
  logic [3:0]  sel;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
`ifdef DEMUX_PARITY_EN
  logic        parity_err;
`endif

  demux1to16_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .sel       (sel),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy)
`ifdef DEMUX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int strobes = 0;
  logic [15:0] exp_dout = '0;

  always @(negedge clk) if (dout_valid === 1'b1) strobes++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // IDLE cycles with noisy in_valid/abort: nothing may move
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bit   = 1'($urandom_range(0, 1));
      abort    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("idle_in_ready", in_ready, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_sel", sel, 0);
      check_eq("idle_dout", dout, exp_dout);
      check_eq("idle_dout_valid", dout_valid, 0);
    end
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  // abort_at < 0 means run to completion; stall adds 3-cycle gaps after beats 0, 7, 14
  task automatic run_frame(input logic [15:0] word, input logic pbit, input int abort_at,
                           input int gap_pct, input bit stall);
    logic [16:0] bits;
    int s0, g, exp_sel;
    bits = {pbit, word};
    abort = 1'($urandom_range(0, 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_in_ready", in_ready, 1);
    s0 = strobes;
    for (int i = 0; i < NB; i++) begin
      exp_sel = (i < 16) ? i : 15;
      g = 0;
      if (stall && (i == 1 || i == 8 || i == 15)) g = 3;
      else if (int'($urandom_range(0, 99)) < gap_pct) g = int'($urandom_range(1, 3));
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
        start    = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        start = 1'b0;
        check_eq("gap_sel", sel, exp_sel);
        check_eq("gap_busy", busy, 1);
      end
      check_eq("beat_sel", sel, exp_sel);
      in_valid = 1'b1;
      in_bit   = bits[i];
      abort    = (i == abort_at);
      start    = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      in_valid = 1'b0;
      abort    = 1'b0;
      start    = 1'b0;
      if (i == abort_at) begin
        check_eq("abort_busy", busy, 0);
        check_eq("abort_sel", sel, 0);
        check_eq("abort_in_ready", in_ready, 0);
        idle_cycles(3);
        check_eq("abort_no_strobe", strobes, s0);
        $display("[TB] frame %h aborted at beat %0d, dout=%h", word, i, dout);
        return;
      end
    end
    check_eq("done_no_strobe_yet", dout_valid, 0);
    check_eq("done_busy", busy, 0);
    @(negedge clk);
    exp_dout = word;
    check_eq("strobe", dout_valid, 1);
    check_eq("dout", dout, exp_dout);
`ifdef DEMUX_PARITY_EN
    check_eq("parity_err", parity_err, (^word) ^ pbit);
`endif
    @(negedge clk);
    check_eq("strobe_one_cycle", dout_valid, 0);
    check_eq("dout_hold", dout, exp_dout);
    check_eq("strobe_count", strobes, s0 + 1);
    $display("[TB] frame %h pbit %0d done, dout=%h", word, pbit, dout);
  endtask

  initial begin
    // power-on reset, released on a falling edge
    @(negedge clk);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    run_frame(16'h3f0a, 1'b0, -1, 0, 1'b0);
    run_frame(16'h3f0a, 1'b1, -1, 0, 1'b0);
    run_frame(16'h0001, 1'b0, -1, 0, 1'b1);
    run_frame(16'hffff, 1'b0, -1, 0, 1'b0);
    run_frame(16'hffff, 1'b0, 8, 0, 1'b0);
    run_frame(16'h1234, 1'b0, -1, 0, 1'b0);
    idle_cycles(2);

    for (int f = 0; f < 24; f++) begin
      run_frame(16'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB - 1)) : -1,
                30, 1'b0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // asynchronous reset in the middle of a frame, asserted mid-cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_dout = '0;
    check_eq("arst_dout", dout, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_sel", sel, 0);
    check_eq("arst_in_ready", in_ready, 0);
    check_eq("arst_dout_valid", dout_valid, 0);
`ifdef DEMUX_PARITY_EN
    check_eq("arst_parity_err", parity_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    run_frame(16'ha5c3, 1'b0, -1, 20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
